// File: rtl/vga_anim_pkg.sv
// Shared types and defaults for the VGA animation controller.
package vga_anim_pkg;

    typedef enum logic [1:0] {
        StRun,
        StPause,
        StStep
    } anim_state_e;

    localparam int unsigned CntWDefault     = 10;
    localparam int unsigned MaxSpeedDefault = 7;

endpackage

// File: rtl/vga_anim_ctrl_if.sv
// Configuration inputs and animation outputs of vga_anim_ctrl.
interface vga_anim_ctrl_if #(
    parameter int unsigned CNT_W = vga_anim_pkg::CntWDefault
) ();

    logic             vsync_in;
    logic [2:0]       cfg_speed;
    logic             cfg_dir;
    logic             cfg_pause;
    logic             step_req;
    logic [CNT_W-1:0] counter;
    logic             frame_tick;
    logic             anim_adv;
    logic             paused;

    modport master (
        output vsync_in, cfg_speed, cfg_dir, cfg_pause, step_req,
        input  counter, frame_tick, anim_adv, paused
    );

    modport slave (
        input  vsync_in, cfg_speed, cfg_dir, cfg_pause, step_req,
        output counter, frame_tick, anim_adv, paused
    );

endinterface

// File: rtl/vga_rise_det.sv
// Registered rising-edge detector; history resets high so a level already
// asserted at reset release is not seen as an edge.
module vga_rise_det (
    input  logic clk,
    input  logic rst_n,
    input  logic sig_i,
    output logic rise_o
);

    logic prev_q;
    logic rise_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev_q <= 1'b1;
            rise_q <= 1'b0;
        end else begin
            prev_q <= sig_i;
            rise_q <= sig_i & ~prev_q;
        end
    end

    assign rise_o = rise_q;

endmodule

// File: rtl/vga_anim_ctrl.sv
// Frame-rate animation counter with run/pause/single-step control, driven
// from the vsync of the video timing generator.
module vga_anim_ctrl
    import vga_anim_pkg::*;
#(
    parameter int unsigned CNT_W     = CntWDefault,
    parameter int unsigned MAX_SPEED = MaxSpeedDefault
) (
    input logic            clk,
    input logic            rst_n,
    vga_anim_ctrl_if.slave bus
);

    localparam logic [2:0]           MaxSpeedCap = (MAX_SPEED > 7) ? 3'd7 : 3'(MAX_SPEED);
    localparam logic [MAX_SPEED:0]   TermOne     = 1;
    localparam logic [MAX_SPEED-1:0] DivOne      = 1;
    localparam logic [CNT_W-1:0]     CntOne      = 1;

    anim_state_e          state_q, state_d;
    logic [MAX_SPEED-1:0] div_q, div_d;
    logic [CNT_W-1:0]     counter_q, counter_d;
    logic                 adv_q, adv_d;
    logic                 tick_q;

    logic                 frame_edge;
    logic                 step_edge;
    logic [2:0]           speed_eff;
    logic [MAX_SPEED:0]   term;
    logic [CNT_W-1:0]     cnt_next;

    vga_rise_det u_vsync_det (
        .clk    (clk),
        .rst_n  (rst_n),
        .sig_i  (bus.vsync_in),
        .rise_o (frame_edge)
    );

    vga_rise_det u_step_det (
        .clk    (clk),
        .rst_n  (rst_n),
        .sig_i  (bus.step_req),
        .rise_o (step_edge)
    );

    // Speeds beyond the divider depth saturate at the deepest setting.
    assign speed_eff = (bus.cfg_speed > MaxSpeedCap) ? MaxSpeedCap : bus.cfg_speed;
    assign term      = (TermOne << speed_eff) - TermOne;
    assign cnt_next  = bus.cfg_dir ? (counter_q - CntOne) : (counter_q + CntOne);

    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        counter_d = counter_q;
        adv_d     = 1'b0;
        case (state_q)
            StRun: begin
                if (bus.cfg_pause) begin
                    state_d = StPause;
                end else if (frame_edge) begin
                    // >= so a speed lowered mid-count fires immediately.
                    if ({1'b0, div_q} >= term) begin
                        counter_d = cnt_next;
                        adv_d     = 1'b1;
                        div_d     = '0;
                    end else begin
                        div_d = div_q + DivOne;
                    end
                end
            end
            StPause: begin
                if (!bus.cfg_pause) begin
                    state_d = StRun;
                    div_d   = '0;
                end else if (step_edge) begin
                    state_d = StStep;
                end
            end
            StStep: begin
                if (frame_edge) begin
                    counter_d = cnt_next;
                    adv_d     = 1'b1;
                    div_d     = '0;
                    state_d   = bus.cfg_pause ? StPause : StRun;
                end
            end
            default: state_d = StRun;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StRun;
            div_q     <= '0;
            counter_q <= '0;
            adv_q     <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            counter_q <= counter_d;
            adv_q     <= adv_d;
            tick_q    <= frame_edge;
        end
    end

    assign bus.counter    = counter_q;
    assign bus.anim_adv   = adv_q;
    assign bus.frame_tick = tick_q;
    assign bus.paused     = (state_q != StRun);

endmodule

// File: tb/tb_vga_anim_ctrl.sv
// Scoreboard bench for vga_anim_ctrl: each frame pushes its expected result,
// a monitor compares on every frame_tick.
module tb_vga_anim_ctrl;
    import vga_anim_pkg::*;

    localparam int unsigned CntW = CntWDefault;

    typedef struct packed {
        logic [CntW-1:0] cnt;
        logic            adv;
        logic            pz;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    vga_anim_ctrl_if #(.CNT_W(CntW)) bus ();

    vga_anim_ctrl #(
        .CNT_W     (CntW),
        .MAX_SPEED (MaxSpeedDefault)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every frame_tick consumes one expected frame result.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.frame_tick) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_frame_tick", 32'(bus.frame_tick), 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("counter", 32'(bus.counter), 32'(e.cnt));
                    check("anim_adv", 32'(bus.anim_adv), 32'(e.adv));
                    check("paused", 32'(bus.paused), 32'(e.pz));
                end
            end else if (bus.anim_adv) begin
                check("adv_without_tick", 32'(bus.anim_adv), 0);
            end
        end
    end

    task automatic send_frame(input int cnt, input bit adv, input bit pz, input bit pause_at_edge);
        exp_t e;
        e.cnt = cnt[CntW-1:0];
        e.adv = adv;
        e.pz  = pz;
        exp_q.push_back(e);
        @(negedge clk) bus.vsync_in = 1'b1;
        @(negedge clk);
        check("tick_early", 32'(bus.frame_tick), 0);
        if (pause_at_edge) bus.cfg_pause = 1'b1;
        @(negedge clk);
        check("tick_latency", 32'(bus.frame_tick), 1);
        repeat (2) @(negedge clk);
        bus.vsync_in = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic pulse_step();
        @(negedge clk) bus.step_req = 1'b1;
        repeat (2) @(negedge clk);
        bus.step_req = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int ticks;
        bus.vsync_in  = 1'b0;
        bus.cfg_speed = 3'd0;
        bus.cfg_dir   = 1'b0;
        bus.cfg_pause = 1'b0;
        bus.step_req  = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_counter", 32'(bus.counter), 0);
        check("rst_tick", 32'(bus.frame_tick), 0);
        check("rst_adv", 32'(bus.anim_adv), 0);
        check("rst_paused", 32'(bus.paused), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Speed 0: advance every frame.
        for (int i = 1; i <= 3; i++) send_frame(i, 1'b1, 1'b0, 1'b0);

        // Speed 2: advance on frames 4, 8, 12.
        bus.cfg_speed = 3'd2;
        for (int i = 1; i <= 12; i++) send_frame(3 + i / 4, (i % 4) == 0, 1'b0, 1'b0);

        // Decrement down through zero, then increment back across the wrap.
        bus.cfg_speed = 3'd0;
        bus.cfg_dir   = 1'b1;
        for (int i = 5; i >= 0; i--) send_frame(i, 1'b1, 1'b0, 1'b0);
        send_frame(1023, 1'b1, 1'b0, 1'b0);
        bus.cfg_dir = 1'b0;
        send_frame(0, 1'b1, 1'b0, 1'b0);

        // Up to 4, step_req in RUN is ignored, then pause at 5.
        for (int i = 1; i <= 4; i++) send_frame(i, 1'b1, 1'b0, 1'b0);
        pulse_step();
        send_frame(5, 1'b1, 1'b0, 1'b0);
        bus.cfg_pause = 1'b1;
        repeat (2) @(negedge clk);
        check("paused_level", 32'(bus.paused), 1);
        for (int f = 1; f <= 10; f++) begin
            if (f == 2 || f == 5 || f == 7) begin
                pulse_step();
                send_frame(f < 5 ? 6 : (f < 7 ? 7 : 8), 1'b1, 1'b1, 1'b0);
            end else begin
                send_frame(f < 2 ? 5 : (f < 5 ? 6 : (f < 7 ? 7 : 8)), 1'b0, 1'b1, 1'b0);
            end
        end

        // Enter STEP, then reset with vsync held high across release.
        pulse_step();
        check("paused_in_step", 32'(bus.paused), 1);
        rst_n         = 1'b0;
        bus.vsync_in  = 1'b1;
        bus.cfg_pause = 1'b0;
        repeat (3) @(negedge clk);
        check("rst2_counter", 32'(bus.counter), 0);
        check("rst2_paused", 32'(bus.paused), 0);
        rst_n = 1'b1;
        ticks = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.frame_tick) ticks++;
        end
        check("no_tick_vsync_high", 32'(ticks), 0);
        bus.vsync_in = 1'b0;
        repeat (2) @(negedge clk);
        send_frame(1, 1'b1, 1'b0, 1'b0);

        // Pause coincident with the terminal frame edge: no advance, then a
        // full divider period after unpausing.
        bus.cfg_speed = 3'd2;
        for (int i = 1; i <= 3; i++) send_frame(1, 1'b0, 1'b0, 1'b0);
        send_frame(1, 1'b0, 1'b1, 1'b1);
        bus.cfg_pause = 1'b0;
        repeat (2) @(negedge clk);
        check("unpaused", 32'(bus.paused), 0);
        for (int i = 1; i <= 4; i++) send_frame(i == 4 ? 2 : 1, i == 4, 1'b0, 1'b0);

        // Lowering speed below the current divider count fires at once.
        send_frame(2, 1'b0, 1'b0, 1'b0);
        send_frame(2, 1'b0, 1'b0, 1'b0);
        bus.cfg_speed = 3'd1;
        send_frame(3, 1'b1, 1'b0, 1'b0);
        send_frame(3, 1'b0, 1'b0, 1'b0);
        send_frame(4, 1'b1, 1'b0, 1'b0);

        repeat (4) @(negedge clk);
        check("queue_empty", 32'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
